// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB writeback path: GPR write select, writeback source, load type.
package mem_wb_stage_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned SEL_W    = 2;
   localparam int unsigned SRC_W    = 2;
   localparam int unsigned LD_W_BITS = 3;
   localparam int unsigned RA_IDX   = 31;

   typedef enum logic [SEL_W-1:0] {
      GPR_NONE = 2'd0,
      GPR_RD   = 2'd1,
      GPR_RT   = 2'd2,
      GPR_RA   = 2'd3
   } gpr_sel_e;

   typedef enum logic [SRC_W-1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2
   } wb_src_e;

   typedef enum logic [LD_W_BITS-1:0] {
      LD_W  = 3'd0,
      LD_H  = 3'd1,
      LD_HU = 3'd2,
      LD_B  = 3'd3,
      LD_BU = 3'd4
   } ld_type_e;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Sub-word load extraction from a word-aligned little-endian read; shared with the D-cache bypass.
module load_ext
   import mem_wb_stage_pkg::*;
(
   input  logic [XLEN-1:0]      dm_rdata,
   input  logic [1:0]           addr,
   input  logic [LD_W_BITS-1:0] ld_type,
   output logic [XLEN-1:0]      result
);

   logic [15:0] half;
   logic [7:0]  byte_sel;

   always_comb begin
      half     = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      byte_sel = dm_rdata[7:0];
      case (addr)
         2'd1:    byte_sel = dm_rdata[15:8];
         2'd2:    byte_sel = dm_rdata[23:16];
         2'd3:    byte_sel = dm_rdata[31:24];
         default: byte_sel = dm_rdata[7:0];
      endcase

      // Unknown load types fall back to a full word.
      case (ld_type)
         LD_H:    result = {{16{half[15]}}, half};
         LD_HU:   result = {16'd0, half};
         LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   result = {24'd0, byte_sel};
         default: result = dm_rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: resolves the GPR destination, formats writeback data,
// exports the forwarding destination and counts retired instructions.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned LINK_OFFSET = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [XLEN-1:0]      ex_mem_instruction,
   input  logic [XLEN-1:0]      ex_mem_pc,
   input  logic [XLEN-1:0]      ex_mem_alu_result,
   input  logic [XLEN-1:0]      dm_rdata,
   input  logic [SEL_W-1:0]     ex_mem_gpr_w_sel,
   input  logic [SRC_W-1:0]     ex_mem_wb_src,
   input  logic [LD_W_BITS-1:0] ex_mem_ld_type,
   output logic [XLEN-1:0]      mem_wb_instruction,
   output logic [SEL_W-1:0]     gpr_w_sel,
   output logic [XLEN-1:0]      gpr_w_data,
   output logic [REG_AW-1:0]    wb_dst,
   output logic                 wb_valid,
   output logic [CNT_W-1:0]     retired_count
);

   logic [XLEN-1:0]   load_data_c;
   logic [REG_AW-1:0] dst_c;
   logic [SEL_W-1:0]  sel_c;
   logic [XLEN-1:0]   data_c;
   logic              valid_c;

   load_ext u_load_ext (
      .dm_rdata (dm_rdata),
      .addr     (ex_mem_alu_result[1:0]),
      .ld_type  (ex_mem_ld_type),
      .result   (load_data_c)
   );

   // Destination resolution with $0 writes folded into "no write".
   always_comb begin
      dst_c = '0;
      sel_c = ex_mem_gpr_w_sel;
      case (ex_mem_gpr_w_sel)
         GPR_RD:  dst_c = ex_mem_instruction[15:11];
         GPR_RT:  dst_c = ex_mem_instruction[20:16];
         GPR_RA:  dst_c = REG_AW'(RA_IDX);
         default: dst_c = '0;
      endcase
      if (dst_c == '0) begin
         sel_c = GPR_NONE;
      end
   end

   // Writeback source select; unknown sources behave as ALU.
   always_comb begin
      case (ex_mem_wb_src)
         WB_MEM:  data_c = load_data_c;
         WB_LINK: data_c = ex_mem_pc + XLEN'(LINK_OFFSET);
         default: data_c = ex_mem_alu_result;
      endcase
      valid_c = (ex_mem_instruction != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wb_instruction <= '0;
         gpr_w_sel          <= GPR_NONE;
         gpr_w_data         <= '0;
         wb_dst             <= '0;
         wb_valid           <= 1'b0;
         retired_count      <= '0;
      end else if (flush) begin
         mem_wb_instruction <= '0;
         gpr_w_sel          <= GPR_NONE;
         gpr_w_data         <= '0;
         wb_dst             <= '0;
         wb_valid           <= 1'b0;
      end else if (!stall) begin
         mem_wb_instruction <= ex_mem_instruction;
         gpr_w_sel          <= sel_c;
         gpr_w_data         <= data_c;
         wb_dst             <= dst_c;
         wb_valid           <= valid_c;
         if (valid_c) begin
            retired_count <= retired_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: behavioural model checked every cycle plus literal spot checks.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [31:0] ex_mem_instruction, ex_mem_pc, ex_mem_alu_result, dm_rdata;
   logic [1:0]  ex_mem_gpr_w_sel, ex_mem_wb_src;
   logic [2:0]  ex_mem_ld_type;
   logic [31:0] mem_wb_instruction, gpr_w_data, retired_count;
   logic [1:0]  gpr_w_sel;
   logic [4:0]  wb_dst;
   logic        wb_valid;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk                (clk),
      .rst                (rst),
      .stall              (stall),
      .flush              (flush),
      .ex_mem_instruction (ex_mem_instruction),
      .ex_mem_pc          (ex_mem_pc),
      .ex_mem_alu_result  (ex_mem_alu_result),
      .dm_rdata           (dm_rdata),
      .ex_mem_gpr_w_sel   (ex_mem_gpr_w_sel),
      .ex_mem_wb_src      (ex_mem_wb_src),
      .ex_mem_ld_type     (ex_mem_ld_type),
      .mem_wb_instruction (mem_wb_instruction),
      .gpr_w_sel          (gpr_w_sel),
      .gpr_w_data         (gpr_w_data),
      .wb_dst             (wb_dst),
      .wb_valid           (wb_valid),
      .retired_count      (retired_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what the stage must write back for a given set of inputs.
   function automatic logic [31:0] ref_data(input logic [31:0] pc, input logic [31:0] alu,
                                            input logic [31:0] rd, input logic [1:0] src,
                                            input logic [2:0] ld);
      int unsigned a;
      logic [31:0] h, b;
      a = int'(alu[1:0]);
      h = (rd >> (16 * (a / 2))) & 32'h0000_FFFF;
      b = (rd >> (8 * a)) & 32'h0000_00FF;
      if (src == 2'd2) return pc + 32'd4;
      if (src != 2'd1) return alu;
      case (ld)
         3'd1:    return (h ^ 32'h8000) - 32'h8000;
         3'd2:    return h;
         3'd3:    return (b ^ 32'h80) - 32'h80;
         3'd4:    return b;
         default: return rd;
      endcase
   endfunction

   function automatic int unsigned ref_dst(input logic [31:0] instr, input logic [1:0] sel);
      case (sel)
         2'd1:    return int'(instr[15:11]);
         2'd2:    return int'(instr[20:16]);
         2'd3:    return 31;
         default: return 0;
      endcase
   endfunction

   // Model state, updated from the same sampled inputs as the DUT.
   logic [31:0] m_instr, m_data, m_cnt;
   logic [1:0]  m_sel;
   logic [4:0]  m_dst;
   logic        m_valid;
   logic        m_known = 1'b0;

   always @(posedge clk) begin
      int unsigned d;
      if (rst) begin
         m_instr = 0; m_sel = 0; m_data = 0; m_dst = 0; m_valid = 0; m_cnt = 0;
         m_known = 1'b1;
      end else if (flush) begin
         m_instr = 0; m_sel = 0; m_data = 0; m_dst = 0; m_valid = 0;
      end else if (!stall) begin
         d       = ref_dst(ex_mem_instruction, ex_mem_gpr_w_sel);
         m_instr = ex_mem_instruction;
         m_dst   = 5'(d);
         m_sel   = (d == 0) ? 2'd0 : ex_mem_gpr_w_sel;
         m_data  = ref_data(ex_mem_pc, ex_mem_alu_result, dm_rdata, ex_mem_wb_src, ex_mem_ld_type);
         m_valid = (ex_mem_instruction != 0);
         if (m_valid) m_cnt = m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (m_known) begin
         check("instr", mem_wb_instruction, m_instr);
         check("sel",   32'(gpr_w_sel),     32'(m_sel));
         check("data",  gpr_w_data,         m_data);
         check("dst",   32'(wb_dst),        32'(m_dst));
         check("valid", 32'(wb_valid),      32'(m_valid));
         check("count", retired_count,      m_cnt);
      end
   end

   task automatic cap(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] rd, input logic [1:0] sel, input logic [1:0] src,
                      input logic [2:0] ld);
      ex_mem_instruction = instr;
      ex_mem_pc          = pc;
      ex_mem_alu_result  = alu;
      dm_rdata           = rd;
      ex_mem_gpr_w_sel   = sel;
      ex_mem_wb_src      = src;
      ex_mem_ld_type     = ld;
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      ex_mem_instruction = $urandom | 32'h1;
      ex_mem_pc          = $urandom;
      ex_mem_alu_result  = $urandom;
      dm_rdata           = $urandom;
      ex_mem_gpr_w_sel   = 2'($urandom_range(0, 3));
      ex_mem_wb_src      = 2'($urandom_range(0, 3));
      ex_mem_ld_type     = 3'($urandom_range(0, 7));
   endtask

   localparam logic [31:0] LOADW = 32'h80FF7F01;
   localparam logic [31:0] LW8   = 32'h8D280000; // rt = $8

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      rand_inputs();
      @(negedge clk);
      rand_inputs();
      @(negedge clk);
      check("rst_instr", mem_wb_instruction, 32'h0);
      check("rst_sel",   32'(gpr_w_sel), 32'(GPR_NONE));
      check("rst_data",  gpr_w_data, 32'h0);
      check("rst_valid", 32'(wb_valid), 32'h0);
      check("rst_count", retired_count, 32'h0);
      rst = 1'b0;

      cap(32'h012A4020, 32'h100, 32'h11, 32'h0, GPR_RD, WB_ALU, LD_W);
      check("add_dst",   32'(wb_dst), 32'd8);
      check("add_data",  gpr_w_data, 32'h11);
      check("add_valid", 32'(wb_valid), 32'd1);
      check("add_count", retired_count, 32'd1);

      cap(LW8, 32'h104, 32'h1003, LOADW, GPR_RT, WB_MEM, LD_B);
      check("lb_a3", gpr_w_data, 32'hFFFFFF80);
      check("lb_dst", 32'(wb_dst), 32'd8);
      cap(LW8, 32'h108, 32'h1001, LOADW, GPR_RT, WB_MEM, LD_BU);
      check("lbu_a1", gpr_w_data, 32'h0000007F);
      cap(LW8, 32'h10C, 32'h1002, LOADW, GPR_RT, WB_MEM, LD_H);
      check("lh_a2", gpr_w_data, 32'hFFFF80FF);
      cap(LW8, 32'h110, 32'h1003, LOADW, GPR_RT, WB_MEM, LD_HU);
      check("lhu_a3", gpr_w_data, 32'h000080FF);
      cap(LW8, 32'h114, 32'h1002, LOADW, GPR_RT, WB_MEM, LD_W);
      check("lw", gpr_w_data, 32'h80FF7F01);
      cap(LW8, 32'h118, 32'h1000, LOADW, GPR_RT, WB_MEM, 3'd7);
      check("ld_undef", gpr_w_data, 32'h80FF7F01);

      cap(32'h0C000C00, 32'h00003000, 32'h55, 32'h0, GPR_RA, WB_LINK, LD_W);
      check("jal_dst",  32'(wb_dst), 32'd31);
      check("jal_data", gpr_w_data, 32'h00003004);
      cap(32'h0C000C00, 32'hFFFFFFFC, 32'h55, 32'h0, GPR_RA, WB_LINK, LD_W);
      check("jal_wrap", gpr_w_data, 32'h00000000);

      cap(32'h01094820, 32'h120, 32'hABCD, LOADW, GPR_RD, 2'd3, LD_B);
      check("src_undef", gpr_w_data, 32'h0000ABCD);
      check("cnt_10", retired_count, 32'd10);

      cap(32'h20000005, 32'h124, 32'h5, 32'h0, GPR_RT, WB_ALU, LD_W);
      check("r0_sel",   32'(gpr_w_sel), 32'(GPR_NONE));
      check("r0_dst",   32'(wb_dst), 32'd0);
      check("r0_valid", 32'(wb_valid), 32'd1);
      check("r0_count", retired_count, 32'd11);

      cap(32'h0, 32'h128, 32'h77, 32'h0, GPR_RD, WB_ALU, LD_W);
      check("nop_valid", 32'(wb_valid), 32'd0);
      check("nop_count", retired_count, 32'd11);

      cap(32'h20000005, 32'h12C, 32'h5, 32'h0, GPR_RT, WB_ALU, LD_W);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         @(negedge clk);
      end
      check("stall_data",  gpr_w_data, 32'h5);
      check("stall_count", retired_count, 32'd12);
      flush = 1'b1;
      rand_inputs();
      @(negedge clk);
      check("flush_instr", mem_wb_instruction, 32'h0);
      check("flush_valid", 32'(wb_valid), 32'd0);
      check("flush_count", retired_count, 32'd12);
      stall = 1'b0; flush = 1'b0;

      cap(32'h012A4020, 32'h200, 32'h99, 32'h0, GPR_RD, WB_ALU, LD_W);
      check("resume_count", retired_count, 32'd13);
      rst = 1'b1;
      cap(32'h012A4020, 32'h204, 32'h9A, 32'h0, GPR_RD, WB_ALU, LD_W);
      check("rst_win_count", retired_count, 32'd0);
      check("rst_win_valid", 32'(wb_valid), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rand_inputs();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
